// File: rtl/timer_array.sv
// timer_array: CHANNELS down-counters (one-shot / auto-reload) with W1C pending flags and one
// registered IRQ. Define TIMER_CASCADE_EN to let channel i>0 tick only on channel i-1 expiry.
module timer_array #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:2]  Addr,
  input  logic        WEn,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        IRQ
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT} state_e;

  state_e           state_q  [CHANNELS];
  state_e           state_d  [CHANNELS];
  logic [WIDTH-1:0] count_q  [CHANNELS];
  logic [WIDTH-1:0] count_d  [CHANNELS];
  logic [WIDTH-1:0] preset_q [CHANNELS];
  logic [WIDTH-1:0] preset_d [CHANNELS];
  logic [1:0]       mode_q   [CHANNELS];
  logic [1:0]       mode_d   [CHANNELS];
  logic             im_q     [CHANNELS];
  logic             im_d     [CHANNELS];
  logic             pend_q   [CHANNELS];
  logic             pend_d   [CHANNELS];
`ifdef TIMER_CASCADE_EN
  logic             casc_q   [CHANNELS];
  logic             casc_d   [CHANNELS];
`endif
  logic             irq_q;
  logic             irq_d;

  logic [1:0] ch_sel;
  logic [1:0] reg_sel;
  logic       wdata_unused;

  assign ch_sel       = Addr[5:4];
  assign reg_sel      = Addr[3:2];
  // Write data bits above WIDTH are dropped on purpose.
  assign wdata_unused = ^WData;
  assign IRQ          = irq_q;

  // Next-state for every channel; the expiry chain runs from channel 0 upward.
  always_comb begin : next_state_comb
    logic prev_exp;
    logic tick;
    logic expire;
    logic wr_ch;
    prev_exp = 1'b0;
    tick     = 1'b1;
    expire   = 1'b0;
    wr_ch    = 1'b0;
    irq_d    = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      preset_d[i] = preset_q[i];
      mode_d[i]   = mode_q[i];
      im_d[i]     = im_q[i];
      wr_ch       = WEn && (ch_sel == 2'(i));
`ifdef TIMER_CASCADE_EN
      casc_d[i]   = casc_q[i];
      tick        = !casc_q[i] || prev_exp;
`else
      tick        = 1'b1;
`endif
      expire   = (state_q[i] == ST_CNT) && tick && (count_q[i] == '0);
      prev_exp = expire;

      case (state_q[i])
        ST_LOAD: begin
          count_d[i] = preset_q[i];
          state_d[i] = ST_CNT;
        end
        ST_CNT: begin
          if (tick) begin
            if (count_q[i] != '0) begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end else begin
              state_d[i] = (mode_q[i] == 2'b01) ? ST_LOAD : ST_IDLE;
            end
          end
        end
        default: ;
      endcase

      if (wr_ch && (reg_sel == REG_PRESET)) begin
        preset_d[i] = WData[WIDTH-1:0];
      end
      // En=0 always stops and freezes; En=1 only starts an idle channel.
      if (wr_ch && (reg_sel == REG_CTRL)) begin
        mode_d[i] = WData[2:1];
        im_d[i]   = WData[3];
`ifdef TIMER_CASCADE_EN
        casc_d[i] = (i != 0) && WData[4];
`endif
        if (!WData[0]) begin
          state_d[i] = ST_IDLE;
          count_d[i] = count_q[i];
        end else if (state_q[i] == ST_IDLE) begin
          state_d[i] = ST_LOAD;
        end
      end

      pend_d[i] = expire ||
                  (pend_q[i] && !(wr_ch && (reg_sel == REG_STATUS) && WData[0]));
      irq_d     = irq_d || (pend_q[i] && im_q[i]);
    end
  end

  // Register read mux; absent channels read 0.
  always_comb begin : read_comb
    logic casc_rd;
    RData   = '0;
    casc_rd = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef TIMER_CASCADE_EN
      casc_rd = casc_q[i];
`else
      casc_rd = 1'b0;
`endif
      if (ch_sel == 2'(i)) begin
        case (reg_sel)
          REG_CTRL:   RData = {27'd0, casc_rd, im_q[i], mode_q[i], (state_q[i] != ST_IDLE)};
          REG_PRESET: RData = 32'(preset_q[i]);
          REG_COUNT:  RData = 32'(count_q[i]);
          REG_STATUS: RData = {31'd0, pend_q[i]};
          default:    RData = '0;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= ST_IDLE;
        count_q[i]  <= '0;
        preset_q[i] <= '0;
        mode_q[i]   <= 2'b00;
        im_q[i]     <= 1'b0;
        pend_q[i]   <= 1'b0;
`ifdef TIMER_CASCADE_EN
        casc_q[i]   <= 1'b0;
`endif
      end
      irq_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        preset_q[i] <= preset_d[i];
        mode_q[i]   <= mode_d[i];
        im_q[i]     <= im_d[i];
        pend_q[i]   <= pend_d[i];
`ifdef TIMER_CASCADE_EN
        casc_q[i]   <= casc_d[i];
`endif
      end
      irq_q <= irq_d;
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// Scoreboard bench for timer_array: stimulus pushes expected read/IRQ values, a negedge
// monitor pops and compares. A second WIDTH=8, CHANNELS=1 instance covers width truncation.
module tb_timer_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [31:0] rdata8;
  logic        irq8;

  typedef struct {
    logic        dut8;
    logic [31:0] exp;
    logic        chk_irq;
    logic        exp_irq;
  } item_t;

  item_t exp_q[$];
  string name_q[$];
  logic  rd_v = 1'b0;
  int    total = 0;
  int    bad = 0;

`ifdef TIMER_CASCADE_EN
  localparam logic [31:0] CASC_RB = 32'h10;
`else
  localparam logic [31:0] CASC_RB = 32'h0;
`endif

  timer_array #(.CHANNELS(2), .WIDTH(32)) dut (
    .Clk(clk), .Rst(rst_n), .Addr(addr), .WEn(wen), .WData(wdata),
    .RData(rdata), .IRQ(irq)
  );

  timer_array #(.CHANNELS(1), .WIDTH(8)) dut8 (
    .Clk(clk), .Rst(rst_n), .Addr(addr), .WEn(wen), .WData(wdata),
    .RData(rdata8), .IRQ(irq8)
  );

  always #5 clk = ~clk;

  // Monitor: compare whenever the stimulus presents a read
  item_t       it;
  string       nm;
  logic [31:0] act;
  logic        act_irq;
  always @(negedge clk) begin
    if (rd_v) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: read presented with no expected value, required one");
      end else begin
        it      = exp_q.pop_front();
        nm      = name_q.pop_front();
        act     = it.dut8 ? rdata8 : rdata;
        act_irq = it.dut8 ? irq8 : irq;
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: RData=%h required %h", nm, act, it.exp);
        end
        if (it.chk_irq) begin
          total++;
          if (act_irq !== it.exp_irq) begin
            bad++;
            $display("FAIL %s_irq: IRQ=%b required %b", nm, act_irq, it.exp_irq);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] ad(input int ch, input int r);
    return {2'(ch), 2'(r)};
  endfunction

  // Auto-reload pending-set edges: period 5 with PRESET=3, then 7 once PRESET=5 is reloaded
  function automatic logic is_set(input int n);
    return (n >= 5 && n <= 25 && (n % 5) == 0) || n == 32 || n == 39;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  task automatic chk(input logic d8, input logic [3:0] a, input logic [31:0] e,
                     input logic ci, input logic ei, input string n);
    item_t x;
    x.dut8 = d8; x.exp = e; x.chk_irq = ci; x.exp_irq = ei;
    addr = a;
    exp_q.push_back(x);
    name_q.push_back(n);
    rd_v = 1'b1;
    @(negedge clk);
    #1;
    rd_v = 1'b0;
  endtask

  initial begin
    // Reset with writes active; reset must win
    rst_n = 1'b0; wen = 1'b1; addr = ad(0, 0); wdata = 32'h1F;
    tick();
    addr = ad(0, 1); wdata = 32'h5;
    tick();
    wen = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        chk(1'b0, ad(c, r), 32'h0, 1'b1, 1'b0, $sformatf("rst_c%0d_r%0d", c, r));
        tick();
      end
    chk(1'b1, ad(0, 0), 32'h0, 1'b1, 1'b0, "rst_w8_ctrl");
    tick();
    chk(1'b0, ad(0, 2), 32'h0, 1'b1, 1'b0, "rst_count_hold");

    // One-shot ch0, PRESET=10
    wr(ad(0, 1), 32'd10);
    wr(ad(0, 0), 32'h9);
    chk(1'b0, ad(0, 2), 32'h0, 1'b1, 1'b0, "os_load_cycle");
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk(1'b0, ad(0, 2), 32'(11 - k), 1'b1, 1'b0, $sformatf("os_cnt_e%0d", k));
    end
    tick();
    chk(1'b0, ad(0, 3), 32'h1, 1'b1, 1'b0, "os_pend_e12");
    tick();
    chk(1'b0, ad(0, 0), 32'h8, 1'b1, 1'b1, "os_ctrl_irq_e13");
    wr(ad(0, 3), 32'h1);
    chk(1'b0, ad(0, 3), 32'h0, 1'b1, 1'b1, "os_clr");
    tick();
    chk(1'b0, ad(0, 3), 32'h0, 1'b1, 1'b0, "os_irq_drop");

    // Auto-reload ch1, PRESET=3 then PRESET=5 mid-count
    wr(ad(1, 1), 32'd3);
    wr(ad(1, 0), 32'hB);
    for (int n = 1; n <= 40; n++) begin
      if (n == 22) wr(ad(1, 1), 32'd5);
      else if (is_set(n - 1)) wr(ad(1, 3), 32'h1);
      else tick();
      chk(1'b0, ad(1, 3), {31'd0, is_set(n)}, 1'b1, is_set(n - 1), $sformatf("ar_e%0d", n));
    end
    wr(ad(1, 0), 32'h0);

    // Disable, hold, re-enable with IM=0, ch0
    wr(ad(0, 1), 32'd20);
    wr(ad(0, 0), 32'h1);
    repeat (9) tick();
    chk(1'b0, ad(0, 2), 32'd12, 1'b1, 1'b0, "dis_at12");
    wr(ad(0, 0), 32'h0);
    chk(1'b0, ad(0, 2), 32'd12, 1'b1, 1'b0, "dis_hold0");
    tick();
    chk(1'b0, ad(0, 0), 32'h0, 1'b1, 1'b0, "dis_ctrl");
    tick();
    chk(1'b0, ad(0, 2), 32'd12, 1'b1, 1'b0, "dis_hold1");
    wr(ad(0, 0), 32'h1);
    chk(1'b0, ad(0, 2), 32'd12, 1'b1, 1'b0, "reen_load_cycle");
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (n == 1) chk(1'b0, ad(0, 2), 32'd20, 1'b1, 1'b0, "reen_reload20");
      else chk(1'b0, ad(0, 3), {31'd0, (n >= 22)}, 1'b1, 1'b0, $sformatf("mask_e%0d", n));
    end
    chk(1'b0, ad(0, 0), 32'h0, 1'b1, 1'b0, "mask_ctrl_after");
    wr(ad(0, 3), 32'h1);

    // PRESET=0 one-shot
    wr(ad(0, 1), 32'd0);
    wr(ad(0, 0), 32'h9);
    tick();
    chk(1'b0, ad(0, 3), 32'h0, 1'b1, 1'b0, "p0_e1");
    tick();
    chk(1'b0, ad(0, 3), 32'h1, 1'b1, 1'b0, "p0_pend_e2");
    tick();
    chk(1'b0, ad(0, 0), 32'h8, 1'b1, 1'b1, "p0_irq_e3");
    wr(ad(0, 3), 32'h1);
    tick();
    chk(1'b0, ad(0, 3), 32'h0, 1'b1, 1'b0, "p0_clr");
    // W1C on the expiry edge: set wins
    wr(ad(0, 0), 32'h9);
    tick();
    wr(ad(0, 3), 32'h1);
    chk(1'b0, ad(0, 3), 32'h1, 1'b1, 1'b0, "set_wins");
    tick();
    chk(1'b0, ad(0, 3), 32'h1, 1'b1, 1'b1, "set_wins_irq");
    wr(ad(0, 3), 32'h1);
    // Reserved mode 10 reads back and behaves as one-shot
    wr(ad(0, 0), 32'h5);
    chk(1'b0, ad(0, 0), 32'h5, 1'b1, 1'b0, "rsv_ctrl");
    tick();
    tick();
    chk(1'b0, ad(0, 3), 32'h1, 1'b1, 1'b0, "rsv_pend");
    tick();
    chk(1'b0, ad(0, 0), 32'h4, 1'b1, 1'b0, "rsv_oneshot");
    wr(ad(0, 3), 32'h1);

    // Absent channels and cascade bit readback
    wr(ad(3, 1), 32'h55);
    wr(ad(3, 0), 32'h9);
    chk(1'b0, ad(3, 1), 32'h0, 1'b1, 1'b0, "ch3_preset");
    tick();
    chk(1'b0, ad(3, 0), 32'h0, 1'b1, 1'b0, "ch3_ctrl");
    tick();
    chk(1'b0, ad(2, 2), 32'h0, 1'b1, 1'b0, "ch2_count");
    wr(ad(1, 0), 32'h10);
    chk(1'b0, ad(1, 0), CASC_RB, 1'b1, 1'b0, "ch1_casc_rb");
    wr(ad(0, 0), 32'h10);
    chk(1'b0, ad(0, 0), 32'h0, 1'b1, 1'b0, "ch0_casc_rb");

`ifdef TIMER_CASCADE_EN
    // ch1 (PRESET=2, cascaded) counts only on ch0 expiries (ch0 period 3)
    wr(ad(0, 1), 32'd1);
    wr(ad(1, 1), 32'd2);
    wr(ad(1, 0), 32'h11);
    wr(ad(0, 0), 32'h3);
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n < 9)
        chk(1'b0, ad(1, 2), (n < 3) ? 32'd2 : ((n < 6) ? 32'd1 : 32'd0), 1'b1, 1'b0,
            $sformatf("casc_cnt_e%0d", n));
      else
        chk(1'b0, ad(1, 3), 32'h1, 1'b1, 1'b0, "casc_pend");
    end
    wr(ad(0, 0), 32'h0);
    wr(ad(1, 0), 32'h0);
    wr(ad(0, 3), 32'h1);
    wr(ad(1, 3), 32'h1);
`endif

    // Reset mid-count overrides a simultaneous write
    wr(ad(1, 1), 32'd100);
    wr(ad(1, 0), 32'hB);
    repeat (5) tick();
    rst_n = 1'b0; wen = 1'b1; addr = ad(0, 1); wdata = 32'h77;
    tick();
    rst_n = 1'b1; wen = 1'b0;
    chk(1'b0, ad(1, 2), 32'h0, 1'b1, 1'b0, "rst2_count");
    tick();
    chk(1'b0, ad(1, 0), 32'h0, 1'b1, 1'b0, "rst2_ctrl");
    tick();
    chk(1'b0, ad(0, 1), 32'h0, 1'b1, 1'b0, "rst2_preset_wr");
    tick();
    chk(1'b0, ad(1, 2), 32'h0, 1'b1, 1'b0, "rst2_count_hold");

    // WIDTH=8 truncation
    wr(ad(0, 1), 32'hFFFF_FFFF);
    chk(1'b1, ad(0, 1), 32'hFF, 1'b1, 1'b0, "w8_preset");
    tick();
    chk(1'b0, ad(0, 1), 32'hFFFF_FFFF, 1'b1, 1'b0, "w32_preset");
    tick();
    chk(1'b1, ad(1, 1), 32'h0, 1'b1, 1'b0, "w8_ch1_absent");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
